// File: rtl/calendar_pkg.sv
// Shared definitions for the calendar date counter.
// Holds the calendar constants, the FSM state type and the Gregorian
// helper functions used by the date registers and the weekday engine.
package calendar_pkg;

  localparam int unsigned YEAR_BASE    = 2000;
  localparam int unsigned YEAR_SPAN    = 128;
  localparam int unsigned MONTH_GAP    = 86;
  localparam int unsigned DAY_GAP      = 32;
  localparam logic [2:0]  BASE_WEEKDAY = 3'd6;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SETTING = 2'd1,
    ST_RECALC  = 2'd2
  } state_t;

  // Absolute year from the stored offset.
  function automatic logic [11:0] full_year(input logic [6:0] off);
    full_year = 12'(YEAR_BASE) + {5'd0, off};
  endfunction

  function automatic logic is_leap(input logic [11:0] year);
    is_leap = (((year % 12'd4) == 12'd0) && ((year % 12'd100) != 12'd0))
              || ((year % 12'd400) == 12'd0);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [11:0] year,
                                               input logic [3:0]  month);
    case (month)
      4'd2:                    days_in_month = is_leap(year) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

  // Weekday shift of the 1st of each month relative to Jan 1 (non-leap).
  function automatic logic [2:0] month_offset(input logic [3:0] month);
    case (month)
      4'd1:    month_offset = 3'd0;
      4'd2:    month_offset = 3'd3;
      4'd3:    month_offset = 3'd3;
      4'd4:    month_offset = 3'd6;
      4'd5:    month_offset = 3'd1;
      4'd6:    month_offset = 3'd4;
      4'd7:    month_offset = 3'd6;
      4'd8:    month_offset = 3'd2;
      4'd9:    month_offset = 3'd5;
      4'd10:   month_offset = 3'd0;
      4'd11:   month_offset = 3'd3;
      4'd12:   month_offset = 3'd5;
      default: month_offset = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/calendar_date_counter_weekday_calc.sv
// calendar_weekday_calc: iterative weekday computation.
// Walks the years from YEAR_BASE up to the target year one per clock,
// accumulating the weekday shift mod 7, then adds the month and day shift.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start           begin a computation (ignored while busy)
//   i_year_off/i_month/i_day  date to evaluate, captured on start
//   o_done            one-cycle pulse when o_weekday is valid
//   o_weekday         result, 0=Sun .. 6=Sat
module calendar_weekday_calc
  import calendar_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [6:0] i_year_off,
  input  logic [3:0] i_month,
  input  logic [4:0] i_day,
  output logic       o_done,
  output logic [2:0] o_weekday
);

  logic       r_busy;
  logic [6:0] r_year_off;
  logic [3:0] r_month;
  logic [4:0] r_day;
  logic [6:0] r_cnt;
  logic [2:0] r_acc;
  logic       r_done;
  logic [2:0] r_weekday;

  logic [2:0] w_step;
  logic [3:0] w_acc_sum;
  logic [2:0] w_acc_next;
  logic       w_leap_adj;
  logic [5:0] w_final_sum;
  logic [2:0] w_final_mod;

  // Per-year shift: a leap year moves the weekday by two.
  assign w_step      = is_leap(full_year(r_cnt)) ? 3'd2 : 3'd1;
  assign w_acc_sum   = {1'b0, r_acc} + {1'b0, w_step};
  assign w_acc_next  = (w_acc_sum >= 4'd7) ? 3'(w_acc_sum - 4'd7) : w_acc_sum[2:0];
  assign w_leap_adj  = is_leap(full_year(r_year_off)) && (r_month > 4'd2);
  assign w_final_sum = {3'd0, r_acc} + {3'd0, month_offset(r_month)}
                     + {5'd0, w_leap_adj} + {1'b0, r_day} - 6'd1;
  assign w_final_mod = 3'(w_final_sum % 6'd7);

  // Year walk followed by a single finishing cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy     <= 1'b0;
      r_year_off <= 7'd0;
      r_month    <= 4'd1;
      r_day      <= 5'd1;
      r_cnt      <= 7'd0;
      r_acc      <= 3'd0;
      r_done     <= 1'b0;
      r_weekday  <= 3'd0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_busy     <= 1'b1;
          r_year_off <= i_year_off;
          r_month    <= i_month;
          r_day      <= i_day;
          r_cnt      <= 7'd0;
          r_acc      <= BASE_WEEKDAY;
        end
      end else if (r_cnt != r_year_off) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 7'd1;
      end else begin
        r_weekday <= w_final_mod;
        r_done    <= 1'b1;
        r_busy    <= 1'b0;
      end
    end
  end

  assign o_done    = r_done;
  assign o_weekday = r_weekday;

endmodule

// File: rtl/calendar_date_counter.sv
// calendar_date_counter: Gregorian date and weekday keeper.
// Advances the date on each rising edge of Day_Passage_Signal, lets the
// user set year/month/day with the crown, and recomputes the weekday after
// a setting session. Outputs BCD digits for the date display.
// Ports:
//   CLOCK_50MHz, RESET         clock, asynchronous active-high reset
//   Enable                     date mode shown; gates settingTrigger
//   Day_Passage_Signal         async level, rising edge = one day
//   settingTrigger             async, rising edge enters setting
//   settingSig_3bit            async, [2] year, [1] month, [0] day + finish
//   DigitalCrownData           async crown position 0..1023
//   year_D3..day_D0            BCD display digits
//   internalYear_off/Month/Day binary date
//   weekday, weekday_valid     0=Sun..6=Sat; valid low during recompute
//   setting_active             high while in setting
module calendar_date_counter
  import calendar_pkg::*;
(
  input  logic       CLOCK_50MHz,
  input  logic       RESET,
  input  logic       Enable,
  input  logic       Day_Passage_Signal,
  input  logic       settingTrigger,
  input  logic [2:0] settingSig_3bit,
  input  logic [9:0] DigitalCrownData,
  output logic [3:0] year_D3,
  output logic [3:0] year_D2,
  output logic [3:0] year_D1,
  output logic [3:0] year_D0,
  output logic [3:0] month_D1,
  output logic [3:0] month_D0,
  output logic [3:0] day_D1,
  output logic [3:0] day_D0,
  output logic [6:0] internalYear_off,
  output logic [3:0] internalMonth,
  output logic [4:0] internalDay,
  output logic [2:0] weekday,
  output logic       weekday_valid,
  output logic       setting_active
);

  // Synchroniser and edge-detector registers
  logic [1:0] r_day_sync;
  logic [1:0] r_trig_sync;
  logic [2:0] r_sig_s1, r_sig_s2;
  logic [9:0] r_crown_s1, r_crown_s2;
  logic       r_day_prev, r_trig_prev;
  logic [2:0] r_sig_prev;

  // Date state
  state_t     r_state, w_state_next;
  logic [6:0] r_year_off;
  logic [3:0] r_month;
  logic [4:0] r_day;
  logic [2:0] r_weekday;
  logic       r_wd_valid;
  logic       r_pending;
  logic       r_start;

  logic       w_day_edge, w_trig_edge;
  logic [2:0] w_sig_edge;
  logic [3:0] w_month_q, w_crown_month;
  logic [5:0] w_crown_day;
  logic [6:0] w_set_year;
  logic [3:0] w_set_month;
  logic [4:0] w_set_dim, w_set_day;
  logic [11:0] w_year_full;
  logic [4:0] w_dim;
  logic [6:0] w_adv_year;
  logic [3:0] w_adv_month;
  logic [4:0] w_adv_day;
  logic [2:0] w_adv_wd;
  logic       w_do_advance, w_do_commit, w_pending_next, w_start_next, w_load_wd;
  logic       w_wd_done;
  logic [2:0] w_wd_calc;

  // Two-flop synchronisers followed by previous-value registers for edges.
  always_ff @(posedge CLOCK_50MHz or posedge RESET) begin
    if (RESET) begin
      r_day_sync  <= 2'b00;
      r_trig_sync <= 2'b00;
      r_sig_s1    <= 3'b000;
      r_sig_s2    <= 3'b000;
      r_crown_s1  <= 10'd0;
      r_crown_s2  <= 10'd0;
      r_day_prev  <= 1'b0;
      r_trig_prev <= 1'b0;
      r_sig_prev  <= 3'b000;
    end else begin
      r_day_sync  <= {r_day_sync[0], Day_Passage_Signal};
      r_trig_sync <= {r_trig_sync[0], settingTrigger};
      r_sig_s1    <= settingSig_3bit;
      r_sig_s2    <= r_sig_s1;
      r_crown_s1  <= DigitalCrownData;
      r_crown_s2  <= r_crown_s1;
      r_day_prev  <= r_day_sync[1];
      r_trig_prev <= r_trig_sync[1];
      r_sig_prev  <= r_sig_s2;
    end
  end

  assign w_day_edge  = r_day_sync[1] & ~r_day_prev;
  assign w_trig_edge = r_trig_sync[1] & ~r_trig_prev;
  assign w_sig_edge  = r_sig_s2 & ~r_sig_prev;

  // Crown decode; the crown is synchronised alongside the setting edges.
  assign w_month_q     = 4'(r_crown_s2 / 10'(MONTH_GAP));
  assign w_crown_month = (w_month_q >= 4'd11) ? 4'd12 : (w_month_q + 4'd1);
  assign w_crown_day   = 6'(r_crown_s2 / 10'(DAY_GAP)) + 6'd1;

  // Year and month commits take effect before the day clamp is evaluated.
  assign w_set_year  = w_sig_edge[2] ? r_crown_s2[9:3] : r_year_off;
  assign w_set_month = w_sig_edge[1] ? w_crown_month : r_month;
  assign w_set_dim   = days_in_month(full_year(w_set_year), w_set_month);
  assign w_set_day   = w_sig_edge[0]
                     ? ((w_crown_day > {1'b0, w_set_dim}) ? w_set_dim : w_crown_day[4:0])
                     : ((r_day > w_set_dim) ? w_set_dim : r_day);

  assign w_year_full = full_year(r_year_off);
  assign w_dim       = days_in_month(w_year_full, r_month);
  assign w_adv_wd    = (r_weekday == 3'd6) ? 3'd0 : (r_weekday + 3'd1);

  // Next date for one day of passage, including month, year and range wrap.
  always_comb begin
    w_adv_year  = r_year_off;
    w_adv_month = r_month;
    w_adv_day   = r_day + 5'd1;
    if (r_day < w_dim) begin
      w_adv_day = r_day + 5'd1;
    end else if (r_month < 4'd12) begin
      w_adv_day   = 5'd1;
      w_adv_month = r_month + 4'd1;
    end else begin
      w_adv_day   = 5'd1;
      w_adv_month = 4'd1;
      w_adv_year  = (r_year_off == 7'(YEAR_SPAN - 1)) ? 7'd0 : (r_year_off + 7'd1);
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50MHz or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and datapath controls.
  always_comb begin
    w_state_next   = r_state;
    w_do_advance   = 1'b0;
    w_do_commit    = 1'b0;
    w_pending_next = r_pending;
    w_start_next   = 1'b0;
    w_load_wd      = 1'b0;
    case (r_state)
      ST_RUN: begin
        // A pending day is consumed here; a fresh edge in the same cycle stays pending.
        if (w_day_edge || r_pending) begin
          w_do_advance   = 1'b1;
          w_pending_next = r_pending & w_day_edge;
        end else begin
          w_pending_next = 1'b0;
        end
        if (w_trig_edge && Enable) begin
          w_state_next = ST_SETTING;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_SETTING: begin
        if (w_day_edge) begin
          w_pending_next = 1'b1;
        end else begin
          w_pending_next = r_pending;
        end
        w_do_commit = |w_sig_edge;
        if (w_sig_edge[0]) begin
          w_state_next = ST_RECALC;
          w_start_next = 1'b1;
        end else begin
          w_state_next = ST_SETTING;
        end
      end
      ST_RECALC: begin
        if (w_day_edge) begin
          w_pending_next = 1'b1;
        end else begin
          w_pending_next = r_pending;
        end
        if (w_wd_done) begin
          w_load_wd    = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_RECALC;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // Date, weekday and handshake registers.
  always_ff @(posedge CLOCK_50MHz or posedge RESET) begin
    if (RESET) begin
      r_year_off <= 7'd0;
      r_month    <= 4'd1;
      r_day      <= 5'd1;
      r_weekday  <= BASE_WEEKDAY;
      r_wd_valid <= 1'b1;
      r_pending  <= 1'b0;
      r_start    <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_start   <= w_start_next;
      if (w_do_advance) begin
        r_year_off <= w_adv_year;
        r_month    <= w_adv_month;
        r_day      <= w_adv_day;
      end else if (w_do_commit) begin
        r_year_off <= w_set_year;
        r_month    <= w_set_month;
        // Only the finishing edge touches the day, re-clamped to the final month.
        if (w_sig_edge[0]) begin
          r_day <= w_set_day;
        end
      end
      if (w_do_advance) begin
        r_weekday <= w_adv_wd;
      end else if (w_load_wd) begin
        r_weekday <= w_wd_calc;
      end
      if (w_start_next) begin
        r_wd_valid <= 1'b0;
      end else if (w_load_wd) begin
        r_wd_valid <= 1'b1;
      end
    end
  end

  calendar_weekday_calc u_weekday_calc (
    .i_clk      (CLOCK_50MHz),
    .i_rst      (RESET),
    .i_start    (r_start),
    .i_year_off (r_year_off),
    .i_month    (r_month),
    .i_day      (r_day),
    .o_done     (w_wd_done),
    .o_weekday  (w_wd_calc)
  );

  assign year_D3  = 4'(w_year_full / 12'd1000);
  assign year_D2  = 4'((w_year_full / 12'd100) % 12'd10);
  assign year_D1  = 4'((w_year_full / 12'd10) % 12'd10);
  assign year_D0  = 4'(w_year_full % 12'd10);
  assign month_D1 = (r_month >= 4'd10) ? 4'd1 : 4'd0;
  assign month_D0 = (r_month >= 4'd10) ? (r_month - 4'd10) : r_month;
  assign day_D1   = 4'(r_day / 5'd10);
  assign day_D0   = 4'(r_day % 5'd10);

  assign internalYear_off = r_year_off;
  assign internalMonth    = r_month;
  assign internalDay      = r_day;
  assign weekday          = r_weekday;
  assign weekday_valid    = r_wd_valid;
  assign setting_active   = (r_state == ST_SETTING);

endmodule
